mips_muldiv_unit: RTL and testbench
===================================

# mips_muldiv_unit

Parametrised iterative multiply/divide unit owning the HI/LO registers of the Harvard MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and replaces the single-cycle combinational multiply/divide path and its two standalone HI/LO registers. The core stalls on `busy`. MFHI/MFLO read the `hi`/`lo` outputs directly.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥4 and even.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- clk_enable  in  1  when low, all state holds (state, counter, hi, lo, busy, done, div_zero)
- start  in  1  operation request; sampled only when busy=0
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored
- rs_val  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- rt_val  in  WIDTH  rt operand (divisor / multiplier)
- busy  out  1  operation in progress; the core must stall issue of MULT/DIV/MFHI/MFLO
- done  out  1  one-cycle pulse after HI/LO update by MULT/MULTU/DIV/DIVU
- div_zero  out  1  valid with done; 1 when the completed DIV/DIVU had rt_val=0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Reset value: hi=0, lo=0, busy=0, done=0, div_zero=0, state IDLE.
- FSM states: IDLE, ITER, FIX.
- IDLE with start=1 and clk_enable=1:
  - MTHI/MTLO: write hi (or lo) from rs_val at that edge. Stay in IDLE, no busy, no done.
  - MULT/MULTU/DIV/DIVU: latch operands and op, clear counter, go to ITER.
  - Ops 6–7: no effect.
- Operand preparation for signed ops: operands are converted to magnitudes, and the result signs are recorded.
- ITER, multiply: radix-2 shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator.
- ITER, divide: restoring division, one quotient bit per cycle.
- ITER runs exactly WIDTH cycles, then moves to FIX.
- FIX: apply sign correction, write {hi,lo}, assert done for the next cycle, return to IDLE.
- Multiply result: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2·WIDTH-bit product.
- Divide result: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
- Divide overflow: DIV of the most negative value by −1 gives lo = most negative value, hi = 0 (wraps, no flag).
- Divide by zero (rt_val=0 at start):
  - Go directly to FIX for one cycle.
  - hi and lo are left unchanged.
  - done=1 and div_zero=1.
- start while busy=1 is ignored. The requester must hold the request until busy falls.
- Reset while in ITER or FIX aborts the operation. All outputs return to reset values at that edge.

## Timing
- Start accepted at edge E0.
- busy is high from after E0 until edge E0+WIDTH+1.
- hi/lo take the new result at edge E0+WIDTH+1.
- done and div_zero are high for the single cycle following E0+WIDTH+1, and busy is low in that cycle.
- A new start is accepted in the same cycle that done is high.
- Divide by zero: FIX is at E0+1, and done is high in the cycle after it.
- MTHI/MTLO: one-edge latency; the value is visible on hi/lo in the next cycle.
- clk_enable low stretches every latency by the number of disabled cycles. done stays high until the next enabled edge.

## Configuration
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU compute the product combinationally and write hi/lo at E0. busy is never asserted for these ops, and done is high in the next cycle. DIV/DIVU are unchanged.
- Undefined: all four arithmetic ops use the iterative path described above.

## Structure
- Package mips_muldiv_pkg holds:
  - the op encoding enum (MD_MULT … MD_MTLO)
  - the FSM state enum
  - the localparam for the counter width, $clog2(WIDTH)+1
- Sub-module mips_divider_core:
  - unsigned restoring divider step datapath (remainder, quotient, divisor registers)
  - interface: load, step, quotient, remainder
  - sign handling and FSM remain in mips_muldiv_unit

## Test plan
- Reset mid-DIV at cycle 10 -> busy=0, hi=lo=0 on the next cycle; a subsequent MULTU 3×5 gives lo=0x0000000F, hi=0.
- MULT rs=0xFFFFFFFF, rt=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. done rises exactly 33 edges after the start edge, and busy is high for 33 cycles.
- MULTU rs=0xFFFFFFFF, rt=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE. Repeat with MULDIV_FAST_MUL_EN -> same values, busy never high, done one cycle after start.
- DIV rs=0xFFFFFFF9 (−7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- MTHI 0x12345678, then DIVU 7/0 -> hi still 0x12345678, done=1 and div_zero=1 two edges after start. A start pulsed during busy for a prior MULT is ignored, and the results are unchanged.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0. With clk_enable low for 5 cycles mid-ITER, done arrives exactly 5 cycles late.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared types for the MIPS multiply/divide unit: op encoding, FSM states, counter sizing.
package mips_muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   localparam int MD_WIDTH_DEFAULT = 32;

   // Counter must hold WIDTH-1 with headroom; width is $clog2(WIDTH)+1.
   function automatic int md_cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/mips_divider_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, operands loaded as magnitudes.
module mips_divider_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH:0]   partial;
   logic [WIDTH:0]   trial;

   // Dividend bits shift out of the quotient register into the partial remainder.
   assign partial = {remainder, quotient[WIDTH-1]};
   assign trial   = partial - {1'b0, divisor_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         quotient  <= '0;
         remainder <= '0;
         divisor_q <= '0;
      end else if (load) begin
         quotient  <= dividend;
         remainder <= '0;
         divisor_q <= divisor;
      end else if (step) begin
         if (!trial[WIDTH]) begin
            remainder <= trial[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b1};
         end else begin
            remainder <= partial[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Define MULDIV_FAST_MUL_EN for single-edge multiplies.
//  state   | meaning
//  IDLE    | waiting; MTHI/MTLO write here, arithmetic ops load operands
//  ITER    | WIDTH shift-add or restoring-divide steps
//  FIX     | sign correction, HI/LO write, done pulse armed
module mips_muldiv_unit
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_enable,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = md_cnt_width(WIDTH);

   md_state_e          state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic               is_div_q, neg_q, rem_neg_q, dz_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     acc_sum;
   logic [WIDTH-1:0]   quo, rem, abs_rs, abs_rt;
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0]   q_res, r_res;
   logic               req_arith, req_div, req_signed, req_fast, req_iter, req_dz;
   logic               load_op, div_step, fix_now, last_iter;

   assign req_arith  = start && (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU);
   assign req_div    = op[1] & ~op[2];
   assign req_signed = ~op[0];
   assign req_dz     = req_div && (rt_val == '0);
`ifdef MULDIV_FAST_MUL_EN
   assign req_fast   = req_arith && !req_div;
`else
   assign req_fast   = 1'b0;
`endif
   assign req_iter   = req_arith && !req_fast;
   assign abs_rs     = (req_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
   assign abs_rt     = (req_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
   assign last_iter  = (cnt == CNT_W'(WIDTH - 1));
   assign acc_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand_q} : '0);

   assign mul_res = neg_q ? -acc : acc;
   assign q_res   = neg_q ? -quo : quo;
   assign r_res   = rem_neg_q ? -rem : rem;

   mips_divider_core #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .reset     (reset),
      .load      (load_op && clk_enable),
      .step      (div_step && clk_enable),
      .dividend  (abs_rs),
      .divisor   (abs_rt),
      .quotient  (quo),
      .remainder (rem)
   );

   always_ff @(posedge clk) begin
      if (reset)           state <= ST_IDLE;
      else if (clk_enable) state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (req_iter) state_nx = req_dz ? ST_FIX : ST_ITER;
         ST_ITER: if (last_iter) state_nx = ST_FIX;
         ST_FIX:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      load_op  = 1'b0;
      div_step = 1'b0;
      fix_now  = 1'b0;
      case (state)
         ST_IDLE: load_op = req_iter;
         ST_ITER: begin
            busy     = 1'b1;
            div_step = is_div_q;
         end
         ST_FIX: begin
            busy    = 1'b1;
            fix_now = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
   always_comb begin
      if (op[0]) fast_prod = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};
      else       fast_prod = {{WIDTH{rs_val[WIDTH-1]}}, rs_val} * {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         mcand_q   <= '0;
         acc       <= '0;
         hi        <= '0;
         lo        <= '0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
      end else if (clk_enable) begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         if (load_op) begin
            cnt       <= '0;
            is_div_q  <= req_div;
            dz_q      <= req_dz;
            neg_q     <= req_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            rem_neg_q <= req_signed && rs_val[WIDTH-1];
            mcand_q   <= abs_rs;
            acc       <= {{WIDTH{1'b0}}, abs_rt};
         end
         if (state == ST_ITER) begin
            cnt <= cnt + CNT_W'(1);
            if (!is_div_q) acc <= {acc_sum, acc[WIDTH-1:1]};
         end
         if (fix_now) begin
            done     <= 1'b1;
            div_zero <= dz_q;
            if (!dz_q) begin
               hi <= is_div_q ? r_res : mul_res[2*WIDTH-1:WIDTH];
               lo <= is_div_q ? q_res : mul_res[WIDTH-1:0];
            end
         end
         if (state == ST_IDLE && start) begin
            if (op == MD_MTHI)      hi <= rs_val;
            else if (op == MD_MTLO) lo <= rs_val;
         end
`ifdef MULDIV_FAST_MUL_EN
         if (state == ST_IDLE && req_fast) begin
            hi   <= fast_prod[2*WIDTH-1:WIDTH];
            lo   <= fast_prod[WIDTH-1:0];
            done <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit; expectations follow MULDIV_FAST_MUL_EN when it is defined.
module tb_mips_muldiv_unit;
   import mips_muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, clk_enable, start;
   logic [2:0]   op;
   logic [W-1:0] rs_val, rt_val;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           lat;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   int           obs_lat, obs_busy;

   always #5 clk = ~clk;

   mips_muldiv_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .start      (start),
      .op         (op),
      .rs_val     (rs_val),
      .rt_val     (rt_val),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero),
      .hi         (hi),
      .lo         (lo)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit fast_mul(input logic [2:0] o);
`ifdef MULDIV_FAST_MUL_EN
      return (o == 3'd0 || o == 3'd1);
`else
      return (o == 3'd7 && o == 3'd6);
`endif
   endfunction

   // Drives one request for a single edge; arithmetic ops push a model result.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t         e;
      longint       sa, sbv, q, r;
      logic [63:0]  p, ua, ub;
      sa = $signed(a);
      sbv = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      e.dz = 1'b0;
      e.hi = m_hi;
      e.lo = m_lo;
      case (o)
         3'd0: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
         3'd1: begin p = ua * ub;  e.hi = p[63:32]; e.lo = p[31:0]; end
         3'd2: if (b == 0) e.dz = 1'b1;
               else begin q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0]; end
         3'd3: if (b == 0) e.dz = 1'b1;
               else begin p = ua / ub; e.lo = p[31:0]; p = ua % ub; e.hi = p[31:0]; end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
         default: ;
      endcase
      if (o <= 3'd3) begin
         e.lat = fast_mul(o) ? 0 : (e.dz ? 1 : W + 1);
         m_hi = e.hi;
         m_lo = e.lo;
         sb.push_back(e);
      end
      op = o; rs_val = a; rt_val = b; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Counts edges until done and the samples with busy high; optionally drops clk_enable.
   task automatic wait_done(input int stall_at, input int stall_len);
      obs_lat = 0;
      obs_busy = 0;
      while (!done && obs_lat < 300) begin
         if (busy) obs_busy++;
         if (obs_lat == stall_at) clk_enable = 1'b0;
         if (obs_lat == stall_at + stall_len) clk_enable = 1'b1;
         step();
         obs_lat++;
      end
      clk_enable = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0 || div_zero !== 1'b0) begin bad++; $display("FAIL reset_done got=%b%b exp=00", done, div_zero); end
      total++; if (hi !== '0 || lo !== '0) begin bad++; $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo); end
   endtask

   task automatic test_mthi_mtlo();
      issue(3'd4, 32'hA5A5_0001, 32'h0);
      total++; if (hi !== 32'hA5A5_0001 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mthi got=%h busy=%b done=%b exp=a5a50001 0 0", hi, busy, done); end
      issue(3'd5, 32'h5A5A_0002, 32'h0);
      total++; if (lo !== 32'h5A5A_0002 || hi !== 32'hA5A5_0001) begin bad++; $display("FAIL mtlo got=%h_%h exp=a5a50001_5a5a0002", hi, lo); end
      issue(3'd6, 32'hFFFF_FFFF, 32'h1);
      step();
      total++; if (hi !== 32'hA5A5_0001 || lo !== 32'h5A5A_0002 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL op6 got=%h_%h busy=%b done=%b exp=a5a50001_5a5a0002 0 0", hi, lo, busy, done); end
   endtask

   task automatic test_mult();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         issue(k[2:0], 32'hFFFF_FFFF, 32'h0000_0002);
         wait_done(-1, 0);
         e = sb.pop_front();
         total++; if (obs_lat != e.lat) begin bad++; $display("FAIL mul%0d_latency got=%0d exp=%0d", k, obs_lat, e.lat); end
         total++; if (obs_busy != e.lat) begin bad++; $display("FAIL mul%0d_busy_cycles got=%0d exp=%0d", k, obs_busy, e.lat); end
         total++; if (hi !== e.hi || lo !== e.lo || busy !== 1'b0 || div_zero !== 1'b0) begin bad++; $display("FAIL mul%0d_result got=%h_%h busy=%b dz=%b exp=%h_%h 0 0", k, hi, lo, busy, div_zero, e.hi, e.lo); end
      end
      total++; if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_const got=%h_%h exp=00000001_fffffffe", hi, lo); end
   endtask

   task automatic test_div();
      exp_t e;
      for (int k = 2; k < 4; k++) begin
         issue(k[2:0], 32'hFFFF_FFF9, 32'h0000_0002);
         wait_done(-1, 0);
         e = sb.pop_front();
         total++; if (obs_lat != W + 1) begin bad++; $display("FAIL div%0d_latency got=%0d exp=%0d", k, obs_lat, W + 1); end
         total++; if (hi !== e.hi || lo !== e.lo || div_zero !== 1'b0) begin bad++; $display("FAIL div%0d_result got=%h_%h dz=%b exp=%h_%h 0", k, hi, lo, div_zero, e.hi, e.lo); end
      end
      total++; if (hi !== 32'h0000_0001 || lo !== 32'h7FFF_FFFC) begin bad++; $display("FAIL divu_const got=%h_%h exp=00000001_7ffffffc", hi, lo); end
   endtask

   task automatic test_div_zero_ignore();
      exp_t        e;
      logic [2:0]  busy_op;
      issue(3'd4, 32'h1234_5678, 32'h0);
      issue(3'd3, 32'h0000_0007, 32'h0);
      wait_done(-1, 0);
      e = sb.pop_front();
      total++; if (obs_lat != 1) begin bad++; $display("FAIL divzero_latency got=%0d exp=1", obs_lat); end
      total++; if (hi !== 32'h1234_5678 || lo !== e.lo || div_zero !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL divzero_result got=%h_%h dz=%b exp=12345678_%h 1", hi, lo, div_zero, e.lo); end
      busy_op = fast_mul(3'd0) ? 3'd2 : 3'd0;
      issue(busy_op, 32'h0000_1234, 32'hFFFF_FFFD);
      step();
      step();
      op = 3'd4; rs_val = 32'hDEAD_BEEF; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(-1, 0);
      e = sb.pop_front();
      total++; if (obs_lat + 3 != e.lat) begin bad++; $display("FAIL ignore_latency got=%0d exp=%0d", obs_lat + 3, e.lat); end
      total++; if (hi !== e.hi || lo !== e.lo) begin bad++; $display("FAIL ignore_result got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
      step();
      total++; if (done !== 1'b0 || busy !== 1'b0 || hi !== e.hi) begin bad++; $display("FAIL ignore_after got=done%b busy%b hi=%h exp=0 0 %h", done, busy, hi, e.hi); end
   endtask

   task automatic test_overflow_stall();
      exp_t e;
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(10, 5);
      e = sb.pop_front();
      total++; if (obs_lat != e.lat + 5) begin bad++; $display("FAIL stall_latency got=%0d exp=%0d", obs_lat, e.lat + 5); end
      total++; if (obs_busy != e.lat + 5) begin bad++; $display("FAIL stall_busy got=%0d exp=%0d", obs_busy, e.lat + 5); end
      total++; if (lo !== 32'h8000_0000 || hi !== 32'h0 || div_zero !== 1'b0) begin bad++; $display("FAIL overflow_result got=%h_%h dz=%b exp=00000000_80000000 0", hi, lo, div_zero); end
   endtask

   task automatic test_reset_abort();
      exp_t e;
      issue(3'd4, 32'hAAAA_AAAA, 32'h0);
      issue(3'd5, 32'h5555_5555, 32'h0);
      issue(3'd2, 32'd100, 32'd7);
      for (int i = 0; i < 9; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      e = sb.pop_back();
      m_hi = '0;
      m_lo = '0;
      total++; if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin bad++; $display("FAIL abort_state got=busy%b done%b %h_%h exp=0 0 0_0", busy, done, hi, lo); end
      issue(3'd1, 32'd3, 32'd5);
      wait_done(-1, 0);
      e = sb.pop_front();
      total++; if (hi !== 32'h0 || lo !== 32'h0000_000F || obs_lat != e.lat) begin bad++; $display("FAIL abort_multu got=%h_%h lat=%0d exp=00000000_0000000f lat=%0d", hi, lo, obs_lat, e.lat); end
   endtask

   task automatic test_random();
      exp_t         e;
      logic [2:0]   o;
      logic [W-1:0] a, b;
      for (int i = 0; i < 12; i++) begin
         o = 3'($urandom_range(0, 3));
         a = $urandom;
         b = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
         if (i % 4 == 1) b = 32'hFFFF_FFFF;
         issue(o, a, b);
         wait_done(-1, 0);
         e = sb.pop_front();
         total++; if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz || obs_lat != e.lat) begin bad++; $display("FAIL rand%0d op=%0d a=%h b=%h got=%h_%h dz=%b lat=%0d exp=%h_%h dz=%b lat=%0d", i, o, a, b, hi, lo, div_zero, obs_lat, e.hi, e.lo, e.dz, e.lat); end
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
   endtask

   initial begin
      reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
      test_reset();
      test_mthi_mtlo();
      test_mult();
      test_div();
      test_div_zero_ignore();
      test_overflow_stall();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
